// File: rtl/keccak_squeeze.sv
// keccak_squeeze
//   Squeeze stage of the Keccak/SHAKE sponge. A permuted 1600-bit state is
//   captured and streamed out one byte per cycle at rate r over a
//   ready/valid handshake. When the rate portion is used up and more bytes
//   are needed, the state is handed to the permutation core. The squeeze
//   then resumes on the returned state.
//
// Ports
//   clock, reset      system clock; synchronous active-high reset
//   start             begin a squeeze (sampled only in IDLE)
//   rate              rate in bytes, legal range 1..RATE_MAX (sampled at start)
//   len               total output bytes requested (sampled at start)
//   linear_s_in       state input; lane x = bits [64x+63:64x]
//   perm_done         permutation result valid on linear_s_in (pulse)
//   linear_s_out      held state, presented to the permutation core
//   perm_req          one-cycle pulse requesting a permutation
//   dout/dout_valid   output byte stream, accepted when dout_ready is high
//   busy              high whenever the FSM is not in IDLE
//   done              one-cycle pulse when the squeeze completes
//   err               one-cycle pulse when start is rejected for a bad rate
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start; rate checked here
// LOAD      | capture linear_s_in, reset byte position and byte counter
// EMIT      | present byte pos of the state; advance on each transfer
// PERM_REQ  | one-cycle permutation request on linear_s_out
// PERM_WAIT | wait for perm_done, then latch the new state
// FIN       | one-cycle done pulse
module keccak_squeeze #(
    parameter int LEN_W    = 16,
    parameter int RATE_MAX = 200
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      rate,
    input  logic [LEN_W-1:0] len,
    input  logic [1599:0]    linear_s_in,
    input  logic             perm_done,
    output logic [1599:0]    linear_s_out,
    output logic             perm_req,
    output logic [7:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_PERM_REQ,
        S_PERM_WAIT,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    // Byte-addressed view of the state: byte b is bits [8b+7:8b], which is
    // byte (b%8) of lane (b/8), little-endian within each lane.
    logic [199:0][7:0] state_arr;
    logic [7:0]        pos_q;
    logic [7:0]        rate_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rem_q;
    logic              err_q;

    logic              rate_ok;
    logic [8:0]        pos_nxt;

    // Full 32-bit compare so that large rates cannot alias into the legal range.
    assign rate_ok = (rate != 32'd0) && (rate <= 32'(RATE_MAX));
    assign pos_nxt = {1'b0, pos_q} + 9'd1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && rate_ok) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (len_q == '0) state_d = S_FIN;
                else             state_d = S_EMIT;
            end
            S_EMIT: begin
                if (dout_ready) begin
                    // The last byte never triggers a permutation, even if it
                    // also ends the rate block.
                    if (rem_q == LEN_W'(1))            state_d = S_FIN;
                    else if (pos_nxt == {1'b0, rate_q}) state_d = S_PERM_REQ;
                end
            end
            S_PERM_REQ: begin
                state_d = S_PERM_WAIT;
            end
            S_PERM_WAIT: begin
                if (perm_done) state_d = S_EMIT;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            state_arr <= '0;
            pos_q     <= '0;
            rate_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == S_IDLE) && start && !rate_ok;
            case (state_q)
                S_IDLE: begin
                    if (start && rate_ok) begin
                        rate_q <= rate[7:0];
                        len_q  <= len;
                    end
                end
                S_LOAD: begin
                    state_arr <= linear_s_in;
                    pos_q     <= '0;
                    rem_q     <= len_q;
                end
                S_EMIT: begin
                    if (dout_ready) begin
                        pos_q <= pos_nxt[7:0];
                        if (rem_q != '0) rem_q <= rem_q - LEN_W'(1);
                    end
                end
                S_PERM_WAIT: begin
                    if (perm_done) begin
                        state_arr <= linear_s_in;
                        pos_q     <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign linear_s_out = state_arr;
    assign dout_valid   = (state_q == S_EMIT);
    assign dout         = (state_q == S_EMIT) ? state_arr[pos_q] : 8'h00;
    assign perm_req     = (state_q == S_PERM_REQ);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FIN);
    assign err          = err_q;

endmodule
